// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: holds one instruction from the instruction queue and presents it
// to the decoder. It then issues the decoded fields to the reservation station or
// to the load/store buffer, together with the ROB tag.
// Optional statistics counters are enabled with the DISPATCH_STAT_EN macro.
module dispatch_ctrl #(
   parameter int ROB_W  = 4,
   parameter int NAME_W = 6
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              clear_in,
   input  logic              iq_valid,
   input  logic [31:0]       iq_inst,
   input  logic [31:0]       iq_pc,
   output logic              iq_pop,
   output logic [31:0]       dec_inst,
   input  logic [NAME_W-1:0] dec_name,
   input  logic [4:0]        dec_rd,
   input  logic [4:0]        dec_rs1,
   input  logic [4:0]        dec_rs2,
   input  logic [31:0]       dec_imm,
   input  logic              rob_full,
   input  logic              rs_full,
   input  logic              lsb_full,
   input  logic [ROB_W-1:0]  rob_tag,
   output logic              issue_valid,
   output logic              issue_to_lsb,
   output logic [NAME_W-1:0] issue_name,
   output logic [4:0]        issue_rd,
   output logic [4:0]        issue_rs1,
   output logic [4:0]        issue_rs2,
   output logic [31:0]       issue_imm,
   output logic [31:0]       issue_pc,
   output logic [ROB_W-1:0]  issue_tag,
`ifdef DISPATCH_STAT_EN
   output logic [31:0]       stat_issued,
   output logic [31:0]       stat_stall,
`endif
   output logic              illegal_out
);

   typedef enum logic [1:0] {EMPTY, READY, STALL} state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   state_t      state, state_nxt;
   logic        hold_v;
   logic [31:0] hold_inst;
   logic [31:0] hold_pc;
   logic        tgt_lsb;
   logic        blocked;
   logic        dispatch;
   logic        drop;

   // An instruction is held whenever the FSM is out of EMPTY
   assign hold_v   = (state != EMPTY);
   assign dec_inst = hold_v ? hold_inst : 32'd0;

   // State register
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)
         state <= EMPTY;
      else
         state <= state_nxt;
   end

   // Next-state logic: a flush empties the slot; otherwise a pop refills it,
   // and a held instruction that cannot leave reflects the current back-pressure
   always_comb begin
      state_nxt = state;
      if (rdy_in) begin
         if (clear_in)
            state_nxt = EMPTY;
         else if (iq_pop)
            state_nxt = READY;
         else if (dispatch || drop)
            state_nxt = EMPTY;
         else if (hold_v)
            state_nxt = blocked ? STALL : READY;
      end
   end

   // Output decode: target steering, back-pressure, dispatch/drop and dequeue strobe
   always_comb begin
      tgt_lsb  = (hold_inst[6:0] == OP_LOAD) || (hold_inst[6:0] == OP_STORE);
      blocked  = rob_full | (tgt_lsb ? lsb_full : rs_full);
      dispatch = rdy_in & hold_v & ~blocked & ~clear_in & (dec_name != '0);
      drop     = rdy_in & hold_v & ~clear_in & (dec_name == '0);
      iq_pop   = rdy_in & ~clear_in & iq_valid & (~hold_v | dispatch | drop);
   end

   // Holding register: data only, qualified by the validity carried in the FSM
   always_ff @(posedge clk_in) begin
      if (iq_pop) begin
         hold_inst <= iq_inst;
         hold_pc   <= iq_pc;
      end
   end

   // Registered issue port; fields hold their value between dispatches
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         issue_valid  <= 1'b0;
         illegal_out  <= 1'b0;
         issue_to_lsb <= 1'b0;
         issue_name   <= '0;
         issue_rd     <= '0;
         issue_rs1    <= '0;
         issue_rs2    <= '0;
         issue_imm    <= '0;
         issue_pc     <= '0;
         issue_tag    <= '0;
      end else begin
         issue_valid <= dispatch;
         illegal_out <= drop;
         if (dispatch) begin
            issue_to_lsb <= tgt_lsb;
            issue_name   <= dec_name;
            issue_rd     <= dec_rd;
            issue_rs1    <= dec_rs1;
            issue_rs2    <= dec_rs2;
            issue_imm    <= dec_imm;
            issue_pc     <= hold_pc;
            issue_tag    <= rob_tag;
         end
      end
   end

`ifdef DISPATCH_STAT_EN
   logic stall_cyc;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // A stall cycle is an enabled cycle where a valid held instruction is blocked
   assign stall_cyc = rdy_in & hold_v & ~clear_in & (dec_name != '0) & blocked;

   // Saturating statistics; a flush does not clear them
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         stat_issued <= '0;
         stat_stall  <= '0;
      end else begin
         if (dispatch)
            stat_issued <= sat_inc(stat_issued);
         if (stall_cyc)
            stat_stall <= sat_inc(stat_stall);
      end
   end
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Self-checking bench for dispatch_ctrl: directed scenarios with literal
// expectations, followed by randomized traffic checked against a behavioural model.
module tb_dispatch_ctrl;

   localparam int ROB_W  = 4;
   localparam int NAME_W = 6;

   logic              clk_in = 1'b0;
   logic              rst_in = 1'b1;
   logic              rdy_in = 1'b1, clear_in = 1'b0, iq_valid = 1'b0;
   logic [31:0]       iq_inst = '0, iq_pc = '0;
   logic              iq_pop;
   logic [31:0]       dec_inst;
   logic [NAME_W-1:0] dec_name;
   logic [4:0]        dec_rd, dec_rs1, dec_rs2;
   logic [31:0]       dec_imm;
   logic              rob_full = 1'b0, rs_full = 1'b0, lsb_full = 1'b0;
   logic [ROB_W-1:0]  rob_tag = '0;
   logic              issue_valid, issue_to_lsb, illegal_out;
   logic [NAME_W-1:0] issue_name;
   logic [4:0]        issue_rd, issue_rs1, issue_rs2;
   logic [31:0]       issue_imm, issue_pc;
   logic [ROB_W-1:0]  issue_tag;
`ifdef DISPATCH_STAT_EN
   logic [31:0]       stat_issued, stat_stall;
`endif

   int errors = 0;
   int checks = 0;
   logic last_pop;

   always #5 clk_in = ~clk_in;

   // Simple decoder: opcode 0x7F is the only illegal encoding
   function automatic logic [NAME_W-1:0] dname(input logic [31:0] i);
      return (i[6:0] == 7'h7F) ? '0 : {1'b1, i[4:0]};
   endfunction

   assign dec_name = dname(dec_inst);
   assign dec_rd   = dec_inst[11:7];
   assign dec_rs1  = dec_inst[19:15];
   assign dec_rs2  = dec_inst[24:20];
   assign dec_imm  = {{20{dec_inst[31]}}, dec_inst[31:20]};

   dispatch_ctrl #(.ROB_W(ROB_W), .NAME_W(NAME_W)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
      .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc), .iq_pop(iq_pop),
      .dec_inst(dec_inst), .dec_name(dec_name), .dec_rd(dec_rd), .dec_rs1(dec_rs1),
      .dec_rs2(dec_rs2), .dec_imm(dec_imm), .rob_full(rob_full), .rs_full(rs_full),
      .lsb_full(lsb_full), .rob_tag(rob_tag), .issue_valid(issue_valid),
      .issue_to_lsb(issue_to_lsb), .issue_name(issue_name), .issue_rd(issue_rd),
      .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_imm(issue_imm),
      .issue_pc(issue_pc), .issue_tag(issue_tag),
`ifdef DISPATCH_STAT_EN
      .stat_issued(stat_issued), .stat_stall(stat_stall),
`endif
      .illegal_out(illegal_out));

   // Behavioural model: one instruction slot plus the last issued packet
   logic              m_hv;
   logic [31:0]       m_inst, m_pc;
   logic              m_iv, m_ill, m_lsb;
   logic [NAME_W-1:0] m_name;
   logic [4:0]        m_rd, m_rs1, m_rs2;
   logic [31:0]       m_imm, m_ipc;
   logic [ROB_W-1:0]  m_tag;
   logic [31:0]       m_si, m_ss;

   task automatic model_reset();
      m_hv = 0; m_inst = '0; m_pc = '0; m_iv = 0; m_ill = 0; m_lsb = 0;
      m_name = '0; m_rd = '0; m_rs1 = '0; m_rs2 = '0; m_imm = '0; m_ipc = '0;
      m_tag = '0; m_si = '0; m_ss = '0;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // The model's view of the instruction currently in the slot
   function automatic logic model_pop();
      logic [6:0] op;
      logic lsb, blk, legal;
      op    = m_inst[6:0];
      lsb   = (op == 7'h03) || (op == 7'h23);
      blk   = rob_full | (lsb ? lsb_full : rs_full);
      legal = dname(m_inst) != '0;
      if (!rdy_in || clear_in || !iq_valid) return 1'b0;
      return !m_hv || (legal && !blk) || !legal;
   endfunction

   // Advance the model across one clock edge using the current inputs
   task automatic model_step();
      logic [6:0] op;
      logic lsb, blk, legal, disp, drp, pop;
      op    = m_inst[6:0];
      lsb   = (op == 7'h03) || (op == 7'h23);
      blk   = rob_full | (lsb ? lsb_full : rs_full);
      legal = dname(m_inst) != '0;
      pop   = model_pop();
      m_iv  = 0;
      m_ill = 0;
      if (rdy_in) begin
         if (clear_in) begin
            m_hv = 0;
         end else begin
            disp = m_hv && legal && !blk;
            drp  = m_hv && !legal;
            if (m_hv && legal && blk) m_ss = (m_ss == '1) ? m_ss : m_ss + 1;
            if (disp) begin
               m_iv = 1; m_lsb = lsb; m_name = dname(m_inst);
               m_rd = m_inst[11:7]; m_rs1 = m_inst[19:15]; m_rs2 = m_inst[24:20];
               m_imm = {{20{m_inst[31]}}, m_inst[31:20]}; m_ipc = m_pc; m_tag = rob_tag;
               m_si = (m_si == '1) ? m_si : m_si + 1;
            end
            m_ill = drp;
            if (pop) begin
               m_hv = 1; m_inst = iq_inst; m_pc = iq_pc;
            end else if (disp || drp) begin
               m_hv = 0;
            end
         end
      end
   endtask

   task automatic compare_outputs();
      chk("issue_valid", 32'(issue_valid), 32'(m_iv));
      chk("illegal_out", 32'(illegal_out), 32'(m_ill));
      chk("issue_to_lsb", 32'(issue_to_lsb), 32'(m_lsb));
      chk("issue_name", 32'(issue_name), 32'(m_name));
      chk("issue_regs", {17'd0, issue_rd, issue_rs1, issue_rs2}, {17'd0, m_rd, m_rs1, m_rs2});
      chk("issue_imm", issue_imm, m_imm);
      chk("issue_pc", issue_pc, m_ipc);
      chk("issue_tag", 32'(issue_tag), 32'(m_tag));
      chk("dec_inst", dec_inst, m_hv ? m_inst : 32'd0);
`ifdef DISPATCH_STAT_EN
      chk("stat_issued", stat_issued, m_si);
      chk("stat_stall", stat_stall, m_ss);
`endif
   endtask

   // One clock cycle: drive, check the combinational strobe, clock, check registers
   task automatic cyc(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic rf, input logic sf, input logic lf,
                      input logic [ROB_W-1:0] tag, input logic clr, input logic rdy);
      @(negedge clk_in);
      iq_valid = v; iq_inst = inst; iq_pc = pc; rob_full = rf; rs_full = sf;
      lsb_full = lf; rob_tag = tag; clear_in = clr; rdy_in = rdy;
      #1;
      last_pop = iq_pop;
      chk("iq_pop", 32'(iq_pop), 32'(model_pop()));
      chk("dec_inst_pre", dec_inst, m_hv ? m_inst : 32'd0);
      model_step();
      @(posedge clk_in);
      #1;
      compare_outputs();
   endtask

   localparam logic [31:0] ADDI1 = 32'h00100093;
   localparam logic [31:0] ADDI2 = 32'h00200113;
   localparam logic [31:0] ADDI3 = 32'h00300193;
   localparam logic [31:0] LW    = 32'h0000A083;
   localparam logic [31:0] BAD   = 32'hFFFFFFFF;

   initial begin
      logic [6:0] ops [5];
      ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h13; ops[3] = 7'h33; ops[4] = 7'h7F;
      model_reset();
      repeat (2) @(negedge clk_in);
      rst_in = 1'b0;
      #1;
      chk("rst_issue_valid", 32'(issue_valid), 32'd0);
      chk("rst_illegal", 32'(illegal_out), 32'd0);
      chk("rst_dec_inst", dec_inst, 32'd0);
      chk("rst_issue_imm", issue_imm, 32'd0);

      // Back-to-back stream of three ADDIs
      cyc(1, ADDI1, 32'h100, 0, 0, 0, 4'd3, 0, 1); chk("s_pop0", 32'(last_pop), 1);
      cyc(1, ADDI2, 32'h104, 0, 0, 0, 4'd5, 0, 1); chk("s_pop1", 32'(last_pop), 1);
      chk("s_iv0", 32'(issue_valid), 1); chk("s_imm0", issue_imm, 1);
      chk("s_tag0", 32'(issue_tag), 5); chk("s_pc0", issue_pc, 32'h100);
      cyc(1, ADDI3, 32'h108, 0, 0, 0, 4'd6, 0, 1); chk("s_pop2", 32'(last_pop), 1);
      chk("s_imm1", issue_imm, 2); chk("s_lsb1", 32'(issue_to_lsb), 0);
      cyc(0, 0, 0, 0, 0, 0, 4'd7, 0, 1);
      chk("s_imm2", issue_imm, 3); chk("s_rd2", 32'(issue_rd), 3); chk("s_tag2", 32'(issue_tag), 7);
      cyc(0, 0, 0, 0, 0, 0, 4'd8, 0, 1);
      chk("s_idle_iv", 32'(issue_valid), 0); chk("s_idle_imm", issue_imm, 3);

      // Load stalled on LSB back-pressure
      cyc(1, LW, 32'h200, 0, 0, 1, 4'd1, 0, 1);
      for (int i = 0; i < 4; i++) begin
         cyc(1, ADDI1, 32'h204, 0, 0, 1, 4'd1, 0, 1);
         chk("lw_stall_pop", 32'(last_pop), 0); chk("lw_stall_iv", 32'(issue_valid), 0);
      end
      cyc(1, ADDI1, 32'h204, 0, 0, 0, 4'd2, 0, 1);
      chk("lw_iv", 32'(issue_valid), 1); chk("lw_lsb", 32'(issue_to_lsb), 1);
      chk("lw_imm", issue_imm, 0); chk("lw_rd", 32'(issue_rd), 1);

      // ROB full holding an RS instruction
      cyc(0, 0, 0, 1, 0, 0, 4'd3, 0, 1); chk("rob_iv", 32'(issue_valid), 0);
      cyc(0, 0, 0, 1, 0, 0, 4'd3, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 4'd4, 0, 1);
      chk("rob_iv1", 32'(issue_valid), 1); chk("rob_pc", issue_pc, 32'h204);
      cyc(0, 0, 0, 0, 0, 0, 4'd5, 0, 1); chk("rob_single", 32'(issue_valid), 0);

      // Flush on a would-be dispatch
      cyc(1, ADDI2, 32'h300, 0, 0, 0, 4'd6, 0, 1);
      cyc(1, ADDI3, 32'h304, 0, 0, 0, 4'd6, 1, 1);
      chk("clr_pop", 32'(last_pop), 0); chk("clr_iv", 32'(issue_valid), 0);
      chk("clr_hold", dec_inst, 0);
      cyc(1, ADDI3, 32'h304, 0, 0, 0, 4'd7, 0, 1); chk("clr_repop", 32'(last_pop), 1);
      cyc(0, 0, 0, 0, 0, 0, 4'd8, 0, 1);
      chk("clr_resume", issue_imm, 3); chk("clr_resume_pc", issue_pc, 32'h304);

      // Illegal instruction dropped while the next one is popped
      cyc(1, BAD, 32'h400, 0, 0, 0, 4'd9, 0, 1);
      cyc(1, ADDI1, 32'h404, 0, 0, 0, 4'd9, 0, 1);
      chk("ill_pop", 32'(last_pop), 1); chk("ill_pulse", 32'(illegal_out), 1);
      chk("ill_noiss", 32'(issue_valid), 0);
      cyc(0, 0, 0, 0, 0, 0, 4'd10, 0, 1);
      chk("ill_next", issue_pc, 32'h404); chk("ill_clear", 32'(illegal_out), 0);

      // rdy_in low freezes everything and ignores clear_in
      cyc(1, ADDI2, 32'h500, 0, 0, 0, 4'd11, 0, 1);
      cyc(1, ADDI3, 32'h504, 0, 0, 0, 4'd11, 1, 0);
      chk("rdy_pop", 32'(last_pop), 0); chk("rdy_hold", dec_inst, ADDI2);
      cyc(0, 0, 0, 0, 0, 0, 4'd12, 0, 1);
      chk("rdy_iss", issue_pc, 32'h500);

      // Asynchronous reset while stalled
      cyc(1, LW, 32'h600, 0, 0, 1, 4'd1, 0, 1);
      cyc(0, 0, 0, 0, 0, 1, 4'd1, 0, 1);
      @(negedge clk_in);
      #2 rst_in = 1'b1;
      #1;
      chk("arst_hold", dec_inst, 0); chk("arst_imm", issue_imm, 0);
      model_reset();
      @(negedge clk_in);
      rst_in = 1'b0;

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] w;
         w = $urandom;
         w[6:0] = ops[$urandom_range(0, 4)];
         cyc(($urandom_range(0, 9) < 7), w, $urandom, ($urandom_range(0, 9) < 2),
             ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 2), ROB_W'($urandom),
             ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) != 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
